// File: rtl/airlock_sequencer.sv
// Airlock interlock controller: owns outer/inner port state and sequences
// timed fill and evacuate operations, refusing any unsafe request.
module airlock_sequencer #(
    parameter int CNT_W       = 4,
    parameter int FILL_CYCLES = 7,
    parameter int EVAC_CYCLES = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             OuterReq,
    input  logic             InnerReq,
    input  logic             FillReq,
    input  logic             EvacReq,
    output logic             OuterOpen,
    output logic             InnerOpen,
    output logic             Filling,
    output logic             Evacuating,
    output logic             Pressurized,
    output logic             Busy,
    output logic             Done,
    output logic             Reject,
    output logic [CNT_W-1:0] Remaining
);

    typedef enum logic [2:0] {
        EVAC_IDLE,
        OUTER_OPEN,
        PRESS_IDLE,
        INNER_OPEN,
        FILLING,
        EVACUATING
    } state_t;

    localparam logic [CNT_W-1:0] FILL_LD = CNT_W'(FILL_CYCLES);
    localparam logic [CNT_W-1:0] EVAC_LD = CNT_W'(EVAC_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] rem_nxt;
    logic [3:0]       req_vec;
    logic [3:0]       acc_vec;
    logic             done_nxt;

    // Request vectors are ordered {evac, fill, outer, inner}; the if/else
    // chains below encode the EvacReq > FillReq > OuterReq > InnerReq priority.
    always_comb begin
        req_vec   = {EvacReq, FillReq, OuterReq, InnerReq};
        acc_vec   = 4'b0000;
        state_nxt = state;
        rem_nxt   = '0;
        done_nxt  = 1'b0;
        case (state)
            EVAC_IDLE: begin
                if (FillReq) begin
                    acc_vec   = 4'b0100;
                    state_nxt = FILLING;
                    rem_nxt   = FILL_LD;
                end else if (OuterReq) begin
                    acc_vec   = 4'b0010;
                    state_nxt = OUTER_OPEN;
                end
            end
            OUTER_OPEN: begin
                if (OuterReq) begin
                    acc_vec   = 4'b0010;
                    state_nxt = EVAC_IDLE;
                end
            end
            PRESS_IDLE: begin
                if (EvacReq) begin
                    acc_vec   = 4'b1000;
                    state_nxt = EVACUATING;
                    rem_nxt   = EVAC_LD;
                end else if (InnerReq) begin
                    acc_vec   = 4'b0001;
                    state_nxt = INNER_OPEN;
                end
            end
            INNER_OPEN: begin
                if (InnerReq) begin
                    acc_vec   = 4'b0001;
                    state_nxt = PRESS_IDLE;
                end
            end
            FILLING: begin
                if (Remaining == CNT_ONE) begin
                    state_nxt = PRESS_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    rem_nxt = Remaining - CNT_ONE;
                end
            end
            EVACUATING: begin
                if (Remaining == CNT_ONE) begin
                    state_nxt = EVAC_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    rem_nxt = Remaining - CNT_ONE;
                end
            end
            default: state_nxt = EVAC_IDLE;
        endcase
    end

    // Outputs decode the next state so they line up with the state register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= EVAC_IDLE;
            OuterOpen   <= 1'b0;
            InnerOpen   <= 1'b0;
            Filling     <= 1'b0;
            Evacuating  <= 1'b0;
            Pressurized <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Reject      <= 1'b0;
            Remaining   <= '0;
        end else begin
            state       <= state_nxt;
            OuterOpen   <= (state_nxt == OUTER_OPEN);
            InnerOpen   <= (state_nxt == INNER_OPEN);
            Filling     <= (state_nxt == FILLING);
            Evacuating  <= (state_nxt == EVACUATING);
            Pressurized <= (state_nxt == PRESS_IDLE) || (state_nxt == INNER_OPEN);
            Busy        <= (state_nxt == FILLING) || (state_nxt == EVACUATING);
            Done        <= done_nxt;
            Reject      <= |(req_vec & ~acc_vec);
            Remaining   <= rem_nxt;
        end
    end

endmodule
